axil_master_arbiter: RTL

//  Round-robin arbiter sharing one AXI4-Lite master port (PL->PS7 GP slave / PL register bus) among
//  N_REQ simple request/response clients. One transaction outstanding at a time; each client gets a
//  one-cycle accept pulse and a one-cycle response pulse. Sits between PL client logic and ps7_bd_wrapper.

---
 rtl/axil_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/axil_master_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/axil_arb_pkg.sv
// Shared types and AXI4-Lite constants for the AXI-Lite master arbiter.
package axil_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4
  } arb_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after index 'last', wrapping modulo N.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  logic [IW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last) + k) % N);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/axil_master_arbiter.sv
// Round-robin sharing of one AXI4-Lite master port among N_REQ clients,
// one transaction outstanding, with one-cycle accept and response pulses.
module axil_master_arbiter
  import axil_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_write,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [N_REQ*STRB_WIDTH-1:0] req_wstrb,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]       rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic                        busy,
  output logic [ADDR_WIDTH-1:0]       m_axi_awaddr,
  output logic [2:0]                  m_axi_awprot,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [DATA_WIDTH-1:0]       m_axi_wdata,
  output logic [STRB_WIDTH-1:0]       m_axi_wstrb,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  output logic [ADDR_WIDTH-1:0]       m_axi_araddr,
  output logic [2:0]                  m_axi_arprot,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [DATA_WIDTH-1:0]       m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e             state_q;
  logic [IW-1:0]          last_q;
  logic [N_REQ-1:0]       grant;
  logic [IW-1:0]          grant_idx;
  logic                   any_req;
  logic                   accept;
  logic                   aw_done;
  logic                   w_done;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [STRB_WIDTH-1:0]  wstrb_q;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req       (req_valid),
    .last      (last_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_req)
  );

  assign accept    = (state_q == IDLE) && any_req;
  assign req_ready = accept ? grant : '0;
  assign busy      = (state_q != IDLE);

  // A channel counts as done once its valid is low or is handshaking this cycle
  assign aw_done = !m_axi_awvalid || m_axi_awready;
  assign w_done  = !m_axi_wvalid  || m_axi_wready;

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = wstrb_q;
  assign m_axi_awprot = PROT_DEFAULT;
  assign m_axi_arprot = PROT_DEFAULT;

  always_ff @(posedge aclk) begin
    if (accept) begin
      addr_q  <= req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_q <= req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
      wstrb_q <= req_wstrb[int'(grant_idx)*STRB_WIDTH +: STRB_WIDTH];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      last_q        <= IW'(N_REQ - 1);
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= '0;
      rsp_rdata     <= '0;
      rsp_resp      <= AXI_RESP_OKAY;
    end else begin
      rsp_valid <= '0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            last_q <= grant_idx;
            if (req_write[grant_idx]) begin
              state_q       <= WR_ADDR;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
            end else begin
              state_q       <= RD_ADDR;
              m_axi_arvalid <= 1'b1;
            end
          end
        end
        WR_ADDR: begin
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            state_q      <= WR_RESP;
            m_axi_bready <= 1'b1;
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid) begin
            state_q      <= IDLE;
            m_axi_bready <= 1'b0;
            rsp_valid    <= N_REQ'(1) << last_q;
            rsp_resp     <= m_axi_bresp;
            rsp_rdata    <= '0;
          end
        end
        RD_ADDR: begin
          if (m_axi_arready) begin
            state_q       <= RD_DATA;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
          end
        end
        RD_DATA: begin
          if (m_axi_rvalid) begin
            state_q      <= IDLE;
            m_axi_rready <= 1'b0;
            rsp_valid    <= N_REQ'(1) << last_q;
            rsp_resp     <= m_axi_rresp;
            rsp_rdata    <= m_axi_rdata;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
